bkram_sd_sequencer: RTL and testbench

//  Backup-RAM (cartridge save) transfer sequencer between user_io's SD-sector interface and port B
//  of the 32 KB nvram dual-port RAM (port A is owned by the system core).
//  On an OSD load/save request it streams 2^SECT_LOG2 512-byte sectors, one sector per
//  sd_rd/sd_wr request, starting at LBA {slot, SECT_LOG2'b0}.

---
 rtl/bk_pkg.sv | 17 +
 rtl/bkram_sd_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_bkram_sd_sequencer.sv | 474 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bk_pkg.sv
// Shared definitions for the backup-RAM SD transfer sequencer:
// sequencer state encoding, sector geometry and parameter defaults.
package bk_pkg;

    localparam int unsigned SECTOR_BYTES  = 512;
    localparam int unsigned BUFF_AW       = $clog2(SECTOR_BYTES);
    localparam int unsigned SECT_LOG2_DEF = 6;
    localparam int unsigned SLOT_BITS_DEF = 2;
    localparam int unsigned TMO_LOG2_DEF  = 24;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2
    } bk_state_e;

endpackage

// File: rtl/bkram_sd_sequencer.sv
// Backup-RAM transfer sequencer: streams 2^SECT_LOG2 SD sectors between
// user_io's sector interface and port B of the nvram on OSD load/save.
//
// Ports:
//   clk_sys, reset                     clock, synchronous active-high reset
//   downloading, img_mounted, img_size arming: save image mounted after ROM download
//   bk_load, bk_save, slot             OSD requests (rising edge acts), save slot
//   sd_lba, sd_rd, sd_wr, sd_ack       sector request handshake with user_io
//   sd_buff_addr/dout/wr, sd_buff_din  sector byte stream
//   nv_addr, nv_we, nv_d, nv_q         nvram port B (nv_q has 1-cycle latency)
//   bk_ena, busy, done, err            armed / active / end pulse / sticky timeout
module bkram_sd_sequencer
    import bk_pkg::*;
#(
    parameter int unsigned SECT_LOG2 = SECT_LOG2_DEF,
    parameter int unsigned SLOT_BITS = SLOT_BITS_DEF,
    parameter int unsigned TMO_LOG2  = TMO_LOG2_DEF
) (
    input  logic                         clk_sys,
    input  logic                         reset,
    input  logic                         downloading,
    input  logic                         img_mounted,
    input  logic [31:0]                  img_size,
    input  logic                         bk_load,
    input  logic                         bk_save,
    input  logic [SLOT_BITS-1:0]         slot,
    output logic [31:0]                  sd_lba,
    output logic                         sd_rd,
    output logic                         sd_wr,
    input  logic                         sd_ack,
    input  logic [BUFF_AW-1:0]           sd_buff_addr,
    input  logic [7:0]                   sd_buff_dout,
    input  logic                         sd_buff_wr,
    output logic [7:0]                   sd_buff_din,
    output logic [SECT_LOG2+BUFF_AW-1:0] nv_addr,
    output logic                         nv_we,
    output logic [7:0]                   nv_d,
    input  logic [7:0]                   nv_q,
    output logic                         bk_ena,
    output logic                         busy,
    output logic                         done,
    output logic                         err
);

    bk_state_e             state_q, state_d;
    logic [31:0]           sd_lba_q, sd_lba_d;
    logic                  sd_rd_q, sd_rd_d;
    logic                  sd_wr_q, sd_wr_d;
    logic                  loading_q, loading_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  bk_ena_q, bk_ena_d;
    logic [TMO_LOG2-1:0]   tmo_q, tmo_d;
    logic                  old_ld_q, old_ld_d;
    logic                  old_sv_q, old_sv_d;
    logic                  old_ack_q, old_ack_d;
    logic                  old_dl_q, old_dl_d;

    logic                  ld_rise;
    logic                  sv_rise;
    logic                  last_sector;

    // Requests only count while armed, so an OSD level held across arming acts as an edge.
    assign ld_rise     = bk_load & bk_ena_q & ~old_ld_q;
    assign sv_rise     = bk_save & bk_ena_q & ~old_sv_q;
    assign last_sector = &sd_lba_q[SECT_LOG2-1:0];

    // Next-state, arming and sequencing logic.
    always_comb begin
        state_d   = state_q;
        sd_lba_d  = sd_lba_q;
        sd_rd_d   = sd_rd_q;
        sd_wr_d   = sd_wr_q;
        loading_d = loading_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = err_q;
        bk_ena_d  = bk_ena_q;
        tmo_d     = tmo_q;
        old_ld_d  = bk_load & bk_ena_q;
        old_sv_d  = bk_save & bk_ena_q;
        old_ack_d = sd_ack;
        old_dl_d  = downloading;

        // A new ROM download disarms; a mount during download re-arms (set has priority).
        if (downloading && !old_dl_q) begin
            bk_ena_d = 1'b0;
        end
        if (downloading && img_mounted && (img_size != 32'd0)) begin
            bk_ena_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (ld_rise || sv_rise) begin
                    loading_d = ld_rise;
                    sd_lba_d  = 32'({slot, SECT_LOG2'(0)});
                    err_d     = 1'b0;
                    busy_d    = 1'b1;
                    sd_rd_d   = ld_rise;
                    sd_wr_d   = ~ld_rise;
                    tmo_d     = '0;
                    state_d   = REQ;
                end
            end
            REQ: begin
                if (sd_ack && !old_ack_q) begin
                    sd_rd_d = 1'b0;
                    sd_wr_d = 1'b0;
                    state_d = XFER;
                end else if (&tmo_q) begin
                    // user_io never answered: give up and flag it
                    sd_rd_d = 1'b0;
                    sd_wr_d = 1'b0;
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_LOG2'(1);
                end
            end
            XFER: begin
                if (!sd_ack && old_ack_q) begin
                    if (last_sector) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        // only the sector index advances; slot bits stay put
                        sd_lba_d = {sd_lba_q[31:SECT_LOG2],
                                    sd_lba_q[SECT_LOG2-1:0] + SECT_LOG2'(1)};
                        sd_rd_d  = loading_q;
                        sd_wr_d  = ~loading_q;
                        tmo_d    = '0;
                        state_d  = REQ;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q   <= IDLE;
            sd_lba_q  <= '0;
            sd_rd_q   <= 1'b0;
            sd_wr_q   <= 1'b0;
            loading_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            bk_ena_q  <= 1'b0;
            tmo_q     <= '0;
            old_ld_q  <= 1'b0;
            old_sv_q  <= 1'b0;
            old_ack_q <= 1'b0;
            old_dl_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            sd_lba_q  <= sd_lba_d;
            sd_rd_q   <= sd_rd_d;
            sd_wr_q   <= sd_wr_d;
            loading_q <= loading_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            bk_ena_q  <= bk_ena_d;
            tmo_q     <= tmo_d;
            old_ld_q  <= old_ld_d;
            old_sv_q  <= old_sv_d;
            old_ack_q <= old_ack_d;
            old_dl_q  <= old_dl_d;
        end
    end

    assign sd_lba  = sd_lba_q;
    assign sd_rd   = sd_rd_q;
    assign sd_wr   = sd_wr_q;
    assign bk_ena  = bk_ena_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;

    // Byte path is straight-through; user_io absorbs the nvram read latency on save.
    assign nv_addr     = {sd_lba_q[SECT_LOG2-1:0], sd_buff_addr};
    assign nv_d        = sd_buff_dout;
    assign nv_we       = sd_buff_wr & sd_ack & loading_q & busy_q;
    assign sd_buff_din = nv_q;

endmodule

// File: tb/tb_bkram_sd_sequencer.sv
// Directed bench for bkram_sd_sequencer with a user_io sector model and nvram model.
module tb_bkram_sd_sequencer;

    localparam int unsigned SECT_LOG2 = 6;
    localparam int unsigned SLOT_BITS = 2;
    localparam int unsigned TMO_LOG2  = 8;
    localparam int unsigned NV_AW     = SECT_LOG2 + 9;
    localparam int unsigned NV_SIZE   = 1 << NV_AW;
    localparam int          SEED_A    = 17;
    localparam int          SEED_B    = 99;

    logic                 clk_sys = 1'b0;
    logic                 reset = 1'b1;
    logic                 downloading = 1'b0;
    logic                 img_mounted = 1'b0;
    logic [31:0]          img_size = 32'd0;
    logic                 bk_load = 1'b0;
    logic                 bk_save = 1'b0;
    logic [SLOT_BITS-1:0] slot = '0;
    logic [31:0]          sd_lba;
    logic                 sd_rd;
    logic                 sd_wr;
    logic                 sd_ack = 1'b0;
    logic [8:0]           sd_buff_addr = 9'd0;
    logic [7:0]           sd_buff_dout = 8'd0;
    logic                 sd_buff_wr = 1'b0;
    logic [7:0]           sd_buff_din;
    logic [NV_AW-1:0]     nv_addr;
    logic                 nv_we;
    logic [7:0]           nv_d;
    logic [7:0]           nv_q;
    logic                 bk_ena;
    logic                 busy;
    logic                 done;
    logic                 err;

    int checks = 0;
    int errors = 0;
    int nv_we_cnt = 0;
    int done_cnt = 0;

    logic [7:0]  nvram [0:NV_SIZE-1];
    logic [7:0]  cap   [0:NV_SIZE-1];
    logic [31:0] seen_lba [$];
    bit          seen_rd  [$];
    bit          seen_wr  [$];

    bkram_sd_sequencer #(
        .SECT_LOG2(SECT_LOG2),
        .SLOT_BITS(SLOT_BITS),
        .TMO_LOG2 (TMO_LOG2)
    ) dut (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .downloading (downloading),
        .img_mounted (img_mounted),
        .img_size    (img_size),
        .bk_load     (bk_load),
        .bk_save     (bk_save),
        .slot        (slot),
        .sd_lba      (sd_lba),
        .sd_rd       (sd_rd),
        .sd_wr       (sd_wr),
        .sd_ack      (sd_ack),
        .sd_buff_addr(sd_buff_addr),
        .sd_buff_dout(sd_buff_dout),
        .sd_buff_wr  (sd_buff_wr),
        .sd_buff_din (sd_buff_din),
        .nv_addr     (nv_addr),
        .nv_we       (nv_we),
        .nv_d        (nv_d),
        .nv_q        (nv_q),
        .bk_ena      (bk_ena),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always #5 clk_sys = ~clk_sys;

    // nvram port B: write-first not needed, registered read
    always @(posedge clk_sys) begin
        if (nv_we === 1'b1) nvram[nv_addr] <= nv_d;
        nv_q <= nvram[nv_addr];
    end

    always @(posedge clk_sys) begin
        if (nv_we === 1'b1) nv_we_cnt <= nv_we_cnt + 1;
        if (done === 1'b1)  done_cnt  <= done_cnt + 1;
    end

    function automatic logic [7:0] img_byte(input int seed, input int addr);
        return 8'(addr * 7 + (addr >> 9) * 13 + seed);
    endfunction

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    // user_io model: wait for a request, ack it, stream nbytes, drop ack
    task automatic serve_sector(input int nbytes, input int seed, output bit seen);
        logic [31:0] lba;
        bit          is_load;
        int          base;
        seen = 1'b0;
        for (int t = 0; t < 50 && !seen; t++) begin
            step();
            if (sd_rd === 1'b1 || sd_wr === 1'b1) seen = 1'b1;
        end
        if (!seen) return;
        lba     = sd_lba;
        is_load = (sd_rd === 1'b1);
        seen_lba.push_back(lba);
        seen_rd.push_back(sd_rd === 1'b1);
        seen_wr.push_back(sd_wr === 1'b1);
        base = int'(lba[SECT_LOG2-1:0]) * 512;
        sd_ack = 1'b1;
        for (int i = 0; i < nbytes; i++) begin
            step();
            if (!is_load && i > 0) cap[base + i - 1] = sd_buff_din;
            sd_buff_addr = 9'(i);
            sd_buff_dout = img_byte(seed, base + i);
            sd_buff_wr   = is_load;
        end
        step();
        if (!is_load) cap[base + nbytes - 1] = sd_buff_din;
        sd_buff_wr = 1'b0;
        sd_ack     = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        checks++;
        if ({sd_rd, sd_wr, bk_ena, busy, done, err, nv_we} !== 7'b0) begin
            errors++;
            $display("FAIL reset_flags got rd,wr,ena,busy,done,err,we=%b exp 0000000",
                     {sd_rd, sd_wr, bk_ena, busy, done, err, nv_we});
        end
        checks++;
        if (sd_lba !== 32'd0) begin
            errors++;
            $display("FAIL reset_lba got %0d exp 0", sd_lba);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_arm();
        int bad = 0;
        bk_save = 1'b1;
        repeat (10) begin
            step();
            if (sd_wr !== 1'b0 || busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL disarmed_save got %0d active cycles exp 0", bad);
        end
        bk_save = 1'b0;
        step();
        downloading = 1'b1;
        step();
        step();
        img_size    = 32'd32768;
        img_mounted = 1'b1;
        step();
        img_mounted = 1'b0;
        downloading = 1'b0;
        step();
        checks++;
        if (bk_ena !== 1'b1) begin
            errors++;
            $display("FAIL arm_after_mount got bk_ena=%b exp 1", bk_ena);
        end
    endtask

    task automatic test_load();
        int we0, dn0, bad, nbad;
        bit ok;
        slot = 2'd2;
        seen_lba.delete(); seen_rd.delete(); seen_wr.delete();
        we0 = nv_we_cnt;
        dn0 = done_cnt;
        bk_load = 1'b1;
        for (int k = 0; k < 64; k++) begin
            serve_sector(512, SEED_A, ok);
            if (!ok) break;
        end
        bk_load = 1'b0;
        repeat (4) step();
        checks++;
        if (seen_lba.size() != 64) begin
            errors++;
            $display("FAIL load_sectors got %0d exp 64", seen_lba.size());
        end
        bad = 0;
        foreach (seen_lba[k]) begin
            if (seen_lba[k] !== 32'(128 + k) || !seen_rd[k] || seen_wr[k]) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL load_lba_order got %0d bad requests exp 0", bad);
        end
        checks++;
        if (nv_we_cnt - we0 != 64 * 512) begin
            errors++;
            $display("FAIL load_nv_we got %0d exp %0d", nv_we_cnt - we0, 64 * 512);
        end
        nbad = 0;
        for (int a = 0; a < int'(NV_SIZE); a++) begin
            if (nvram[a] !== img_byte(SEED_A, a)) nbad++;
        end
        checks++;
        if (nbad != 0) begin
            errors++;
            $display("FAIL load_nvram got %0d wrong bytes exp 0", nbad);
        end
        checks++;
        if (done_cnt - dn0 != 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL load_done got pulses=%0d busy=%b exp 1,0", done_cnt - dn0, busy);
        end
    endtask

    task automatic test_save();
        int we0, dn0, bad, nbad;
        bit ok;
        slot = 2'd1;
        seen_lba.delete(); seen_rd.delete(); seen_wr.delete();
        we0 = nv_we_cnt;
        dn0 = done_cnt;
        bk_save = 1'b1;
        serve_sector(512, SEED_A, ok);
        slot = 2'd0;
        for (int k = 1; k < 64 && ok; k++) serve_sector(512, SEED_A, ok);
        bk_save = 1'b0;
        repeat (4) step();
        checks++;
        if (seen_lba.size() != 64) begin
            errors++;
            $display("FAIL save_sectors got %0d exp 64", seen_lba.size());
        end
        bad = 0;
        foreach (seen_lba[k]) begin
            if (seen_lba[k] !== 32'(64 + k) || seen_rd[k] || !seen_wr[k]) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL save_lba_order got %0d bad requests exp 0", bad);
        end
        checks++;
        if (nv_we_cnt != we0) begin
            errors++;
            $display("FAIL save_no_nv_we got %0d writes exp 0", nv_we_cnt - we0);
        end
        nbad = 0;
        for (int a = 0; a < int'(NV_SIZE); a++) begin
            if (cap[a] !== img_byte(SEED_A, a)) nbad++;
        end
        checks++;
        if (nbad != 0) begin
            errors++;
            $display("FAIL save_stream got %0d wrong bytes exp 0", nbad);
        end
        checks++;
        if (done_cnt - dn0 != 1) begin
            errors++;
            $display("FAIL save_done got %0d pulses exp 1", done_cnt - dn0);
        end
    endtask

    task automatic test_both_edges();
        int we0, dn0, bad, nbad, extra;
        bit ok;
        slot = 2'd3;
        seen_lba.delete(); seen_rd.delete(); seen_wr.delete();
        we0 = nv_we_cnt;
        dn0 = done_cnt;
        bk_load = 1'b1;
        bk_save = 1'b1;
        ok = 1'b1;
        for (int k = 0; k < 5 && ok; k++) serve_sector(4, SEED_B, ok);
        bk_load = 1'b0;
        bk_save = 1'b0;
        step();
        bk_save = 1'b1;
        step();
        for (int k = 5; k < 64 && ok; k++) serve_sector(4, SEED_B, ok);
        extra = 0;
        repeat (20) begin
            step();
            if (sd_rd !== 1'b0 || sd_wr !== 1'b0 || busy !== 1'b0) extra++;
        end
        bk_save = 1'b0;
        checks++;
        if (seen_lba.size() != 64) begin
            errors++;
            $display("FAIL both_sectors got %0d exp 64", seen_lba.size());
        end
        bad = 0;
        foreach (seen_lba[k]) begin
            if (seen_lba[k] !== 32'(192 + k) || !seen_rd[k] || seen_wr[k]) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL both_load_wins got %0d bad requests exp 0", bad);
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("FAIL busy_edge_not_queued got %0d active cycles exp 0", extra);
        end
        nbad = 0;
        for (int s = 0; s < 64; s++) begin
            for (int i = 0; i < 4; i++) begin
                if (nvram[s * 512 + i] !== img_byte(SEED_B, s * 512 + i)) nbad++;
            end
        end
        checks++;
        if (nv_we_cnt - we0 != 256 || nbad != 0) begin
            errors++;
            $display("FAIL both_nvram got writes=%0d bad=%0d exp 256,0", nv_we_cnt - we0, nbad);
        end
        checks++;
        if (done_cnt - dn0 != 1) begin
            errors++;
            $display("FAIL both_done got %0d pulses exp 1", done_cnt - dn0);
        end
    endtask

    task automatic test_timeout();
        int dn0, high;
        bit idle;
        slot = 2'd0;
        dn0 = done_cnt;
        bk_load = 1'b1;
        high = 0;
        for (int c = 0; c < 400; c++) begin
            step();
            if (sd_rd === 1'b1) high++;
            else if (high > 0) break;
        end
        checks++;
        if (high < 250 || high > 260) begin
            errors++;
            $display("FAIL timeout_len got %0d req cycles exp 250..260", high);
        end
        checks++;
        if ({sd_rd, err, busy} !== 3'b010) begin
            errors++;
            $display("FAIL timeout_state got rd,err,busy=%b exp 010", {sd_rd, err, busy});
        end
        repeat (3) step();
        checks++;
        if (done_cnt - dn0 != 1) begin
            errors++;
            $display("FAIL timeout_done got %0d pulses exp 1", done_cnt - dn0);
        end
        bk_load = 1'b0;
        step();
        bk_save = 1'b1;
        step();
        checks++;
        if ({err, sd_wr, busy} !== 3'b011) begin
            errors++;
            $display("FAIL restart_clears_err got err,wr,busy=%b exp 011", {err, sd_wr, busy});
        end
        idle = 1'b0;
        for (int c = 0; c < 400 && !idle; c++) begin
            step();
            if (busy === 1'b0) idle = 1'b1;
        end
        checks++;
        if (!idle || err !== 1'b1) begin
            errors++;
            $display("FAIL second_timeout got idle=%b err=%b exp 1,1", idle, err);
        end
        bk_save = 1'b0;
        step();
    endtask

    task automatic test_rearm();
        downloading = 1'b1;
        step();
        checks++;
        if (bk_ena !== 1'b0) begin
            errors++;
            $display("FAIL dl_rise_disarms got %b exp 0", bk_ena);
        end
        img_size    = 32'd0;
        img_mounted = 1'b1;
        step();
        checks++;
        if (bk_ena !== 1'b0) begin
            errors++;
            $display("FAIL zero_size_no_arm got %b exp 0", bk_ena);
        end
        img_size = 32'd32768;
        step();
        checks++;
        if (bk_ena !== 1'b1) begin
            errors++;
            $display("FAIL mount_arms got %b exp 1", bk_ena);
        end
        img_mounted = 1'b0;
        downloading = 1'b0;
        repeat (2) step();
        downloading = 1'b1;
        img_mounted = 1'b1;
        step();
        checks++;
        if (bk_ena !== 1'b1) begin
            errors++;
            $display("FAIL set_wins_over_clear got %b exp 1", bk_ena);
        end
        downloading = 1'b0;
        img_mounted = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        bit ok, req;
        slot = 2'd1;
        bk_load = 1'b1;
        ok = 1'b1;
        for (int k = 0; k < 10 && ok; k++) serve_sector(2, SEED_B, ok);
        req = 1'b0;
        for (int t = 0; t < 50 && !req; t++) begin
            step();
            if (sd_rd === 1'b1) req = 1'b1;
        end
        checks++;
        if (!req || sd_lba !== 32'd74) begin
            errors++;
            $display("FAIL mid_sector10 got req=%b lba=%0d exp 1,74", req, sd_lba);
        end
        reset = 1'b1;
        step();
        checks++;
        if ({sd_rd, sd_wr, busy, bk_ena, done, err} !== 6'b0 || sd_lba !== 32'd0) begin
            errors++;
            $display("FAIL mid_reset got rd,wr,busy,ena,done,err=%b lba=%0d exp 000000,0",
                     {sd_rd, sd_wr, busy, bk_ena, done, err}, sd_lba);
        end
        reset = 1'b0;
        repeat (3) step();
        checks++;
        if (sd_rd !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle got rd=%b busy=%b exp 0,0", sd_rd, busy);
        end
        bk_load = 1'b0;
    endtask

    initial begin
        test_reset();
        test_arm();
        test_load();
        test_save();
        test_both_edges();
        test_timeout();
        test_rearm();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
